ram_wb_arbiter: RTL and testbench
=================================

// Module: ram_wb_arbiter
// PURPOSE
//  Round-robin Wishbone B3 arbiter that shares one slave (the on-chip RAM) between nm masters.
//  Sits between CPU instruction/data ports (and a debug/DMA master) and the RAM slave.
//  Grants whole bus tenures (cyc high to cyc low), so classic, incrementing and wrap bursts pass through unbroken.
//  A per-tenure watchdog errors out a stalled slave.
// PARAMETERS
//  dw      32   data width
//  aw      32   address width
//  nm      2    number of masters, 2..8; master k occupies slice [k*W +: W] of every m_* vector
//  tmo     256  watchdog limit in cycles, >=2; a strobe waiting this long without ack/err/rty is errored
// PORTS
//  wb_clk_i   in   1      clock
//  wb_rst_i   in   1      synchronous reset, active high
//  m_adr_i    in   nm*aw  master addresses
//  m_dat_i    in   nm*dw  master write data
//  m_sel_i    in   nm*4   master byte selects
//  m_we_i     in   nm     master write enables
//  m_cyc_i    in   nm     master cycle requests
//  m_stb_i    in   nm     master strobes
//  m_cti_i    in   nm*3   master cycle type identifiers
//  m_bte_i    in   nm*2   master burst type extensions
//  m_dat_o    out  dw     read data, broadcast to all masters
//  m_ack_o    out  nm     per-master ack
//  m_err_o    out  nm     per-master error
//  m_rty_o    out  nm     per-master retry
//  s_adr_o    out  aw     slave address (granted master's)
//  s_dat_o    out  dw     slave write data
//  s_sel_o    out  4      slave byte selects
//  s_we_o     out  1      slave write enable
//  s_cyc_o    out  1      slave cycle
//  s_stb_o    out  1      slave strobe
//  s_cti_o    out  3      slave cycle type
//  s_bte_o    out  2      slave burst type
//  s_dat_i    in   dw     slave read data
//  s_ack_i    in   1      slave ack
//  s_err_i    in   1      slave error
//  s_rty_i    in   1      slave retry
// BEHAVIOUR
//  States
//   - IDLE: no grant.
//   - BUSY: grant index g, width clog2(nm).
//  Round-robin pointer p: reset 0.
//  IDLE
//   - If any m_cyc_i is high, grant the first requester found scanning p, p+1, ... (mod nm).
//   - The grant is registered: BUSY starts on the next edge, so arbitration latency is 1 cycle.
//  BUSY
//   - s_adr/dat/sel/we/cti/bte_o are the granted master's signals.
//   - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g].
//   - m_ack/err/rty_o[g] = s_ack/err/rty_i, combinational with no added latency. All other bits are 0.
//   - Requests from other masters are ignored until release.
//  Release
//   - Trigger: m_cyc_i[g] sampled low.
//   - Transition to IDLE; p <= (g+1) mod nm.
//   - s_cyc_o is therefore low for at least 1 cycle between tenures.
//  Outside BUSY: all s_* outputs and all m_ack/err/rty_o are 0. m_dat_o = s_dat_i always.
//  Reset: after a reset edge the block is in IDLE with p=0, so all outputs above are 0.
//   - Reset mid-burst abandons the tenure; no ack reaches any master after that edge.
//  Watchdog
//   - Counter clears on: entering BUSY, any s_ack_i/s_err_i/s_rty_i, or m_stb_i[g] low.
//   - It otherwise increments while BUSY.
//   - On reaching tmo-1: m_err_o[g]=1 for exactly that cycle, s_stb_o forced to 0 that cycle, counter cleared.
//   - The grant is kept until the master drops cyc.
//  Simultaneous events
//   - Master g drops cyc in the same cycle another master raises cyc: release happens first. The new grant is decided in IDLE next cycle.
//   - A requester that drops cyc before being granted leaves no trace.
// TESTING
//  1. Reset. m_cyc_i=2'b11 from cycle 1 -> m0 is granted at cycle 2. m0 does 4 single reads of 0x0..0xC, then drops cyc.
//     -> IDLE for 1 cycle, then m1 is granted. p ends at 0 after m1 releases.
//  2. m1 runs an 8-beat cti=010, bte=10 burst while m0 requests mid-burst.
//     -> 8 acks go to m1 only and m_ack_o[0] stays 0; m0 is granted 2 cycles after m1 drops cyc.
//  3. Both masters request continuously, 1-beat tenures, for 10 tenures.
//     -> grants alternate 0,1,0,1...; neither master waits more than 1 tenure plus 2 cycles.
//  4. tmo=16 with a slave that never acks.
//     -> m_err_o[g] pulses 1 cycle at 15 cycles after strobe assertion; s_stb_o is low that cycle.
//  5. Reset asserted during beat 3 of a burst.
//     -> the next cycle has s_cyc_o=0 and m_ack_o=0; the first grant after reset goes to m0.

Source files
------------

// File: rtl/ram_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one RAM slave between nm masters.
// Grants whole cyc tenures and errors out strobes the slave leaves hanging for tmo cycles.
module ram_wb_arbiter #(
    parameter int unsigned dw  = 32,
    parameter int unsigned aw  = 32,
    parameter int unsigned nm  = 2,
    parameter int unsigned tmo = 256
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [nm*aw-1:0]   m_adr_i,
    input  logic [nm*dw-1:0]   m_dat_i,
    input  logic [nm*4-1:0]    m_sel_i,
    input  logic [nm-1:0]      m_we_i,
    input  logic [nm-1:0]      m_cyc_i,
    input  logic [nm-1:0]      m_stb_i,
    input  logic [nm*3-1:0]    m_cti_i,
    input  logic [nm*2-1:0]    m_bte_i,
    output logic [dw-1:0]      m_dat_o,
    output logic [nm-1:0]      m_ack_o,
    output logic [nm-1:0]      m_err_o,
    output logic [nm-1:0]      m_rty_o,
    output logic [aw-1:0]      s_adr_o,
    output logic [dw-1:0]      s_dat_o,
    output logic [3:0]         s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic [2:0]         s_cti_o,
    output logic [1:0]         s_bte_o,
    input  logic [dw-1:0]      s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_rty_i
);

    localparam int unsigned GW = $clog2(nm);
    localparam int unsigned TW = $clog2(tmo);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   wdog_q, wdog_d;

    logic            req_found;
    logic [GW-1:0]   req_idx;
    int unsigned     scan_idx;
    logic            busy;
    logic            timeout;
    logic            slv_resp;

    assign busy     = (state_q == StBusy);
    assign slv_resp = s_ack_i | s_err_i | s_rty_i;
    // Independent of the slave response so the forced-low strobe cannot loop back through ack.
    assign timeout  = busy && m_stb_i[grant_q] && (wdog_q == TW'(tmo - 1));
    assign m_dat_o  = s_dat_i;

    // First requester at or after the round-robin pointer.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < nm; i++) begin
            scan_idx = (int'(ptr_q) + i) % nm;
            if (!req_found && m_cyc_i[scan_idx]) begin
                req_found = 1'b1;
                req_idx   = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            StIdle: begin
                if (req_found) begin
                    state_d = StBusy;
                    grant_d = req_idx;
                    wdog_d  = '0;
                end
            end
            StBusy: begin
                if (!m_cyc_i[grant_q]) begin
                    state_d = StIdle;
                    ptr_d   = (grant_q == GW'(nm - 1)) ? '0 : grant_q + 1'b1;
                    wdog_d  = '0;
                end else if (!m_stb_i[grant_q] || slv_resp || timeout) begin
                    wdog_d  = '0;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            s_adr_o          = m_adr_i[grant_q*aw +: aw];
            s_dat_o          = m_dat_i[grant_q*dw +: dw];
            s_sel_o          = m_sel_i[grant_q*4 +: 4];
            s_we_o           = m_we_i[grant_q];
            s_cyc_o          = m_cyc_i[grant_q];
            s_stb_o          = m_stb_i[grant_q] & ~timeout;
            s_cti_o          = m_cti_i[grant_q*3 +: 3];
            s_bte_o          = m_bte_i[grant_q*2 +: 2];
            m_ack_o[grant_q] = s_ack_i;
            m_err_o[grant_q] = s_err_i | timeout;
            m_rty_o[grant_q] = s_rty_i;
        end
    end

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Directed bench for ram_wb_arbiter: two masters, tmo=16, combinational-ack slave model.
module tb_ram_wb_arbiter;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] m_adr, m_dat;
    logic [7:0]  m_sel;
    logic [1:0]  m_we, m_cyc, m_stb;
    logic [5:0]  m_cti;
    logic [3:0]  m_bte;
    logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [1:0]  m_ack_o, m_err_o, m_rty_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_ack_i;
    logic        ack_en;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
    assign s_dat_i = s_adr_o ^ KEY;

    ram_wb_arbiter #(.dw(32), .aw(32), .nm(2), .tmo(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_sel_i  (m_sel),
        .m_we_i   (m_we),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_cti_i  (m_cti),
        .m_bte_i  (m_bte),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_rty_o  (m_rty_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_cti_o  (s_cti_o),
        .s_bte_o  (s_bte_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (1'b0),
        .s_rty_i  (1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic [31:0] adr,
                         input logic [2:0] cti, input logic [1:0] bte);
        m_cyc[k]          = cyc;
        m_stb[k]          = stb;
        m_we[k]           = 1'b0;
        m_adr[k*32 +: 32] = adr;
        m_dat[k*32 +: 32] = adr ^ 32'h1111_0000;
        m_sel[k*4 +: 4]   = 4'hF;
        m_cti[k*3 +: 3]   = cti;
        m_bte[k*2 +: 2]   = bte;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] acked;
        int n_grant, last_c, err_at, n_err;

        rst = 1'b1;
        ack_en = 1'b1;
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        step();
        step();
        @(negedge clk);
        check("rst s_cyc", s_cyc_o, 0);
        check("rst s_stb", s_stb_o, 0);
        check("rst ack", m_ack_o, 0);
        check("rst err", m_err_o, 0);

        // T1: both request, m0 wins, 4 single reads, then m1.
        step();
        rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 32'h0, 3'b000, 2'b00);
        set_m(1, 1'b1, 1'b1, 32'h100, 3'b000, 2'b00);
        @(negedge clk);
        check("t1 latency", s_cyc_o, 0);
        for (int b = 0; b < 4; b++) begin
            step();
            set_m(0, 1'b1, 1'b1, b * 4, 3'b000, 2'b00);
            @(negedge clk);
            check("t1 adr", s_adr_o, b * 4);
            check("t1 ack", m_ack_o, 2'b01);
            check("t1 rdata", m_dat_o, (b * 4) ^ KEY);
            check("t1 wdata", s_dat_o, (b * 4) ^ 32'h1111_0000);
        end
        step();
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        @(negedge clk);
        check("t1 release cyc", s_cyc_o, 0);
        step();
        @(negedge clk);
        check("t1 idle ack", m_ack_o, 0);
        step();
        @(negedge clk);
        check("t1 m1 ack", m_ack_o, 2'b10);
        check("t1 m1 adr", s_adr_o, 32'h100);
        step();
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        step();

        // T2: m1 8-beat wrap burst, m0 requests mid-burst.
        set_m(1, 1'b1, 1'b1, 32'h200, 3'b010, 2'b10);
        for (int b = 0; b < 8; b++) begin
            step();
            set_m(1, 1'b1, 1'b1, 32'h200 + b * 4, (b == 7) ? 3'b111 : 3'b010, 2'b10);
            if (b == 2) set_m(0, 1'b1, 1'b1, 32'h300, 3'b000, 2'b00);
            @(negedge clk);
            check("t2 ack m1 only", m_ack_o, 2'b10);
            check("t2 cti", s_cti_o, (b == 7) ? 3'b111 : 3'b010);
            check("t2 bte", s_bte_o, 2'b10);
        end
        step();
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        @(negedge clk);
        check("t2 drop+0", m_ack_o, 0);
        step();
        @(negedge clk);
        check("t2 drop+1", m_ack_o, 0);
        step();
        @(negedge clk);
        check("t2 drop+2 m0", m_ack_o, 2'b01);
        check("t2 m0 adr", s_adr_o, 32'h300);
        step();
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        step();

        // T3: continuous 1-beat tenures; pointer sits at 1 after m0's tenure.
        acked = 2'b00;
        n_grant = 0;
        last_c = 0;
        for (int c = 0; c < 30; c++) begin
            set_m(0, !acked[0], !acked[0], 32'h400, 3'b000, 2'b00);
            set_m(1, !acked[1], !acked[1], 32'h410, 3'b000, 2'b00);
            @(negedge clk);
            acked = m_ack_o;
            if (m_ack_o != 2'b00 && n_grant < 10) begin
                check("t3 order", m_ack_o, (n_grant % 2 == 0) ? 2'b10 : 2'b01);
                if (n_grant > 0) check("t3 gap", c - last_c, 3);
                last_c = c;
                n_grant++;
            end
            step();
        end
        check("t3 grants", n_grant, 10);
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        step();

        // T4: slave never acks; watchdog fires 15 cycles after strobe.
        ack_en = 1'b0;
        err_at = -1;
        n_err = 0;
        set_m(0, 1'b1, 1'b1, 32'h500, 3'b000, 2'b00);
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (i == 0) check("t4 stb start", s_stb_o, 1);
            if (m_err_o != 2'b00) begin
                n_err++;
                if (err_at < 0) begin
                    err_at = i;
                    check("t4 stb forced", s_stb_o, 0);
                    check("t4 err vec", m_err_o, 2'b01);
                end
            end
        end
        check("t4 err cycle", err_at, 15);
        check("t4 err count", n_err, 1);
        step();
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        ack_en = 1'b1;
        step();
        step();

        // T5: reset during beat 3 of an m1 burst.
        set_m(1, 1'b1, 1'b1, 32'h600, 3'b010, 2'b00);
        for (int b = 0; b < 3; b++) begin
            step();
            set_m(1, 1'b1, 1'b1, 32'h600 + b * 4, 3'b010, 2'b00);
            if (b == 2) rst = 1'b1;
            @(negedge clk);
            if (b < 2) check("t5 beat ack", m_ack_o, 2'b10);
        end
        step();
        rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 32'h700, 3'b000, 2'b00);
        @(negedge clk);
        check("t5 post rst cyc", s_cyc_o, 0);
        check("t5 post rst ack", m_ack_o, 0);
        step();
        @(negedge clk);
        check("t5 first grant", m_ack_o, 2'b01);
        check("t5 m0 adr", s_adr_o, 32'h700);
        step();
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
